// File: rtl/btn_evt_pkg.sv
// Shared types for the button gesture decoder: event codes, FSM states and a
// helper that tells which states run the shared timing counter.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SINGLE = 2'b01,
    EVT_DOUBLE = 2'b10,
    EVT_LONG   = 2'b11
  } evt_code_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  function automatic logic is_timed(input state_t s);
    return (s == PRESS1) || (s == GAP) || (s == PRESS2);
  endfunction

endpackage

// File: rtl/btn_evt_slot.sv
// Single-entry valid/ready event slot with a sticky overrun flag.
// A push on the accept cycle replaces the outgoing event; a push into a full,
// non-accepting slot is dropped and latches overrun_o.
module btn_evt_slot
  import btn_evt_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  evt_code_t  code_i,
  output logic       evt_valid_o,
  output logic [1:0] evt_code_o,
  input  logic       evt_ready_i,
  output logic       overrun_o
);

  logic      r_valid;
  evt_code_t r_code;
  logic      r_overrun;
  logic      w_accept;
  logic      w_load;

  assign w_accept = r_valid & evt_ready_i;
  assign w_load   = push_i & (~r_valid | w_accept);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid   <= 1'b0;
      r_code    <= EVT_NONE;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_code  <= code_i;
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_code  <= EVT_NONE;
      end
      if (push_i && !w_load) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign evt_valid_o = r_valid;
  assign evt_code_o  = r_code;
  assign overrun_o   = r_overrun;

  // Code reads 00 exactly when the slot is empty.
  a_code_tracks_valid : assert property (@(posedge clk_i) disable iff (!rst_ni)
    evt_valid_o == (evt_code_o != 2'b00));

  a_stable_under_backpressure : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (evt_valid_o && !evt_ready_i) |=> (evt_valid_o && $stable(evt_code_o)));

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced press/release pulses into SINGLE, DOUBLE or LONG
// gestures and hands them to the consumer through a one-entry slot.
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 26,
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 15_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_down_i,
  input  logic       btn_up_i,
  output logic       evt_valid_o,
  output logic [1:0] evt_code_o,
  input  logic       evt_ready_i,
  output logic       hold_o,
  output logic       overrun_o
);

  localparam logic [CNT_WIDTH-1:0] LongLast = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GapLast  = CNT_WIDTH'(GAP_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_hold;
  logic                 w_down;
  logic                 w_up;
  logic                 w_long_hit;
  logic                 w_gap_hit;
  logic                 w_push;
  evt_code_t            w_code;

  // Down and up in the same cycle is a glitch and counts as neither.
  assign w_down     = btn_down_i & ~btn_up_i;
  assign w_up       = btn_up_i & ~btn_down_i;
  assign w_long_hit = (r_cnt == LongLast);
  assign w_gap_hit  = (r_cnt == GapLast);

  // Pulses are tested before the timeouts so an edge on the threshold cycle wins.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_code       = EVT_NONE;
    case (r_state)
      IDLE: begin
        if (w_down) w_state_next = PRESS1;
      end
      PRESS1: begin
        if (w_up) begin
          w_state_next = GAP;
        end else if (w_long_hit) begin
          w_push       = 1'b1;
          w_code       = EVT_LONG;
          w_state_next = HOLD;
        end
      end
      GAP: begin
        if (w_down) begin
          w_state_next = PRESS2;
        end else if (w_gap_hit) begin
          w_push       = 1'b1;
          w_code       = EVT_SINGLE;
          w_state_next = IDLE;
        end
      end
      PRESS2: begin
        if (w_up) begin
          w_push       = 1'b1;
          w_code       = EVT_DOUBLE;
          w_state_next = IDLE;
        end else if (w_long_hit) begin
          w_push       = 1'b1;
          w_code       = EVT_DOUBLE;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_up) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Every threshold forces a state change, so the counter never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if ((w_state_next != r_state) || !is_timed(r_state)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold <= 1'b0;
    end else begin
      r_hold <= (w_state_next == HOLD);
    end
  end

  assign hold_o = r_hold;

  btn_evt_slot u_slot (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (w_push),
    .code_i      (w_code),
    .evt_valid_o (evt_valid_o),
    .evt_code_o  (evt_code_o),
    .evt_ready_i (evt_ready_i),
    .overrun_o   (overrun_o)
  );

  a_state_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_state inside {IDLE, PRESS1, GAP, PRESS2, HOLD});

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: directed vector tables for the gesture corner
// cases, then random pulses checked against a timestamp-based gesture model.
module tb_btn_event_decoder;

  localparam int unsigned L = 8;
  localparam int unsigned G = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       down = 1'b0;
  logic       up = 1'b0;
  logic       ready = 1'b1;
  logic       o_valid;
  logic [1:0] o_code;
  logic       o_hold;
  logic       o_ovr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_event_decoder #(
    .CNT_WIDTH   (4),
    .LONG_CYCLES (L),
    .GAP_CYCLES  (G)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .btn_down_i  (down),
    .btn_up_i    (up),
    .evt_valid_o (o_valid),
    .evt_code_o  (o_code),
    .evt_ready_i (ready),
    .hold_o      (o_hold),
    .overrun_o   (o_ovr)
  );

  typedef struct {
    bit       down;
    bit       up;
    bit       ready;
    int       n;
    bit [4:0] exp;  // {valid, code, hold, overrun}
  } vec_t;

  vec_t tbl[$];

  function automatic void e(bit d, bit u, bit r, int n, bit v, bit [1:0] c, bit h, bit o);
    vec_t x;
    x.down  = d;
    x.up    = u;
    x.ready = r;
    x.n     = n;
    x.exp   = {v, c, h, o};
    tbl.push_back(x);
  endfunction

  task automatic check(input string name, input bit [4:0] exp);
    bit [4:0] got;
    got = {o_valid, o_code, o_hold, o_ovr};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got valid=%b code=%b hold=%b ovr=%b, required valid=%b code=%b hold=%b ovr=%b",
               name, $time, got[4], got[3:2], got[1], got[0], exp[4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Reference model: gesture phase plus the time it was entered; slot as a queue.
  localparam int PhIdle = 0, PhDown1 = 1, PhGap = 2, PhDown2 = 3, PhHeld = 4;
  int       ph, t_mark, now;
  bit [1:0] q_slot[$];
  bit       m_ovr;

  task automatic model_reset();
    ph = PhIdle;
    t_mark = 0;
    now = 0;
    q_slot.delete();
    m_ovr = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit u, input bit r);
    bit       dd, uu, push;
    bit [1:0] c;
    int       el, nxt;
    dd = d && !u;
    uu = u && !d;
    push = 1'b0;
    c = 2'b00;
    el = now - t_mark;
    nxt = ph;
    case (ph)
      PhIdle:  if (dd) nxt = PhDown1;
      PhDown1: if (uu) nxt = PhGap;
               else if (el == int'(L) - 1) begin push = 1; c = 2'b11; nxt = PhHeld; end
      PhGap:   if (dd) nxt = PhDown2;
               else if (el == int'(G) - 1) begin push = 1; c = 2'b01; nxt = PhIdle; end
      PhDown2: if (uu) begin push = 1; c = 2'b10; nxt = PhIdle; end
               else if (el == int'(L) - 1) begin push = 1; c = 2'b10; nxt = PhHeld; end
      default: if (uu) nxt = PhIdle;
    endcase
    if (nxt != ph) t_mark = now + 1;
    ph = nxt;
    now++;
    if (q_slot.size() > 0 && r) void'(q_slot.pop_front());
    if (push) begin
      if (q_slot.size() == 0) q_slot.push_back(c);
      else m_ovr = 1'b1;
    end
  endtask

  function automatic bit [4:0] model_exp();
    bit [1:0] c;
    c = (q_slot.size() > 0) ? q_slot[0] : 2'b00;
    return {q_slot.size() > 0, c, ph == PhHeld, m_ovr};
  endfunction

  task automatic apply(input bit d, input bit u, input bit r);
    @(negedge clk);
    down = d;
    up = u;
    ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string seg);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        apply(tbl[i].down, tbl[i].up, tbl[i].ready);
        check($sformatf("%s[%0d]", seg, i), tbl[i].exp);
      end
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    down = 1'b0;
    up = 1'b0;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single
    e(1,0,1,1, 0,0,0,0); e(0,0,1,2, 0,0,0,0); e(0,1,1,1, 0,0,0,0);
    e(0,0,1,5, 0,0,0,0); e(0,0,1,1, 1,1,0,0); e(0,0,1,2, 0,0,0,0);
    // Double
    e(1,0,1,1, 0,0,0,0); e(0,0,1,1, 0,0,0,0); e(0,1,1,1, 0,0,0,0); e(0,0,1,2, 0,0,0,0);
    e(1,0,1,1, 0,0,0,0); e(0,0,1,1, 0,0,0,0); e(0,1,1,1, 1,2,0,0); e(0,0,1,8, 0,0,0,0);
    // Long, down ignored in hold, release
    e(1,0,1,1, 0,0,0,0); e(0,0,1,7, 0,0,0,0); e(0,0,1,1, 1,3,1,0); e(0,0,1,10, 0,0,1,0);
    e(1,0,1,1, 0,0,1,0); e(0,1,1,1, 0,0,0,0); e(0,0,1,10, 0,0,0,0);
    // Second press times out: DOUBLE then hold
    e(1,0,1,1, 0,0,0,0); e(0,1,1,1, 0,0,0,0); e(1,0,1,1, 0,0,0,0); e(0,0,1,7, 0,0,0,0);
    e(0,0,1,1, 1,2,1,0); e(0,0,1,2, 0,0,1,0); e(0,1,1,1, 0,0,0,0); e(0,0,1,3, 0,0,0,0);
    // Glitch in idle, glitch in gap
    e(1,1,1,3, 0,0,0,0); e(0,0,1,10, 0,0,0,0);
    e(1,0,1,1, 0,0,0,0); e(0,1,1,1, 0,0,0,0); e(0,0,1,2, 0,0,0,0); e(1,1,1,1, 0,0,0,0);
    e(0,0,1,2, 0,0,0,0); e(0,0,1,1, 1,1,0,0); e(0,0,1,1, 0,0,0,0);
    // Down exactly on the gap threshold
    e(1,0,1,1, 0,0,0,0); e(0,1,1,1, 0,0,0,0); e(0,0,1,5, 0,0,0,0); e(1,0,1,1, 0,0,0,0);
    e(0,0,1,1, 0,0,0,0); e(0,1,1,1, 1,2,0,0); e(0,0,1,1, 0,0,0,0);
    // Backpressure: SINGLE held, DOUBLE dropped, overrun sticky
    e(1,0,0,1, 0,0,0,0); e(0,1,0,1, 0,0,0,0); e(0,0,0,5, 0,0,0,0); e(0,0,0,1, 1,1,0,0);
    e(0,0,0,3, 1,1,0,0); e(1,0,0,1, 1,1,0,0); e(0,1,0,1, 1,1,0,0); e(1,0,0,1, 1,1,0,0);
    e(0,1,0,1, 1,1,0,1); e(0,0,0,2, 1,1,0,1); e(0,0,1,1, 0,0,0,1); e(0,0,1,3, 0,0,0,1);
    // Fill slot again and park in PRESS2 before reset
    e(1,0,0,1, 0,0,0,1); e(0,1,0,1, 0,0,0,1); e(0,0,0,5, 0,0,0,1); e(0,0,0,1, 1,1,0,1);
    e(1,0,0,1, 1,1,0,1); e(0,1,0,1, 1,1,0,1); e(1,0,0,1, 1,1,0,1);
    run_table("dir");

    // Asynchronous reset mid-gesture with the slot full
    @(negedge clk);
    down = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_async", 5'b0);
    @(posedge clk);
    #1;
    check("reset_held", 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;

    e(0,0,1,10, 0,0,0,0);
    e(1,0,1,1, 0,0,0,0); e(0,0,1,2, 0,0,0,0); e(0,1,1,1, 0,0,0,0);
    e(0,0,1,5, 0,0,0,0); e(0,0,1,1, 1,1,0,0); e(0,0,1,3, 0,0,0,0);
    run_table("post_rst");

    // Random pulses against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit d, u, r;
      d = ($urandom_range(0, 7) == 0);
      u = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 3) != 0);
      apply(d, u, r);
      model_step(d, u, r);
      check("random", model_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
